// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the direct-mapped cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    FLUSH = 2'b11
  } state_e;

  // Word-in-line index width.
  function automatic int unsigned calc_wi(input int unsigned words);
    return $clog2(words);
  endfunction

  // Line index width.
  function automatic int unsigned calc_li(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Bit position of the tag field's LSB within a byte address.
  function automatic int unsigned calc_tag_lsb(input int unsigned words, input int unsigned lines);
    return 2 + $clog2(words) + $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_tag_valid_array.sv
// Per-line {valid, tag} storage with a single write port and combinational hit lookup.
module cache_tag_valid_array
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned TAG_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_valid,
  input  logic [$clog2(LINES)-1:0]   wr_line,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [$clog2(LINES)-1:0]   rd_line,
  input  logic [TAG_W-1:0]           rd_tag,
  output logic                       hit_c
);

  logic [LINES-1:0]             valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]  tag_q, tag_d;

  // Tag is only rewritten when a line becomes valid; invalidation leaves it stale.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_en) begin
      valid_d[wr_line] = wr_valid;
      if (wr_valid) begin
        tag_d[wr_line] = wr_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q <= tag_d;
  end

  assign hit_c = valid_q[rd_line] && (tag_q[rd_line] == rd_tag);

endmodule

// File: rtl/cache_ctrl_dm_param.sv
// Direct-mapped write-through, no-write-allocate cache controller with multi-beat refill.
// Optional hit/miss counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_ctrl_dm_param
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINES  = 32,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic                       Flush,
  input  logic [ADDR_W-1:0]          Address,
  input  logic                       Mem_Done,
  output logic                       Mem_Stall,
  output logic                       Cache_Read_En,
  output logic                       Cache_Write_En,
  output logic                       Memory_Read_En,
  output logic                       Memory_Write_En,
  output logic [$clog2(LINES)-1:0]   Line_number,
  output logic [$clog2(WORDS)-1:0]   block_num_Addr,
  output logic [TAG_W-1:0]           Addr_Tag,
  output logic [ADDR_W-1:0]          Mem_Addr
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]                Hit_Count,
  output logic [31:0]                Miss_Count
`endif
);

  localparam int unsigned WI      = calc_wi(WORDS);
  localparam int unsigned LI      = calc_li(LINES);
  localparam int unsigned TAG_LSB = calc_tag_lsb(WORDS, LINES);

  state_e          state_q, state_d;
  logic [WI-1:0]   cnt_q, cnt_d;
  logic [LI-1:0]   fcnt_q, fcnt_d;
  logic            hit_q, hit_d;

  logic [WI-1:0]    blk;
  logic [LI-1:0]    line;
  logic [TAG_W-1:0] tag;
  logic             hit_c;
  logic             tv_wr_en;
  logic             tv_wr_valid;
  logic [LI-1:0]    tv_wr_line;

  assign blk  = Address[2 +: WI];
  assign line = Address[2+WI +: LI];
  assign tag  = Address[TAG_LSB +: TAG_W];

  assign tv_wr_line = (state_q == FLUSH) ? fcnt_q : line;

  cache_tag_valid_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tag_valid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (tv_wr_en),
    .wr_valid (tv_wr_valid),
    .wr_line  (tv_wr_line),
    .wr_tag   (tag),
    .rd_line  (line),
    .rd_tag   (tag),
    .hit_c    (hit_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (Flush) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end else if (MemWrite) begin
          state_d = WRITE;
          hit_d   = hit_c;
        end else if (MemRead && !hit_c) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (Mem_Done) begin
          cnt_d = cnt_q + WI'(1);
          if (cnt_q == WI'(WORDS - 1)) begin
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        if (Mem_Done) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + LI'(1);
        if (fcnt_q == LI'(LINES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; the IDLE stall is combinational so a read hit costs no cycles.
  always_comb begin
    Mem_Stall       = 1'b0;
    Cache_Read_En   = 1'b0;
    Cache_Write_En  = 1'b0;
    Memory_Read_En  = 1'b0;
    Memory_Write_En = 1'b0;
    Line_number     = line;
    block_num_Addr  = blk;
    Addr_Tag        = tag;
    Mem_Addr        = Address;
    Mem_Addr[1:0]   = 2'b00;
    tv_wr_en        = 1'b0;
    tv_wr_valid     = 1'b0;
    if (rst) begin
      Cache_Read_En = MemRead && !MemWrite;
    end else begin
      case (state_q)
        IDLE: begin
          Cache_Read_En = MemRead && !MemWrite;
          Mem_Stall     = Flush | MemWrite | (MemRead & !hit_c);
        end
        READ: begin
          Mem_Stall      = 1'b1;
          Memory_Read_En = 1'b1;
          block_num_Addr = cnt_q;
          Mem_Addr       = {Address[ADDR_W-1:2+WI], cnt_q, 2'b00};
          Cache_Write_En = Mem_Done;
          tv_wr_en       = Mem_Done && (cnt_q == WI'(WORDS - 1));
          tv_wr_valid    = 1'b1;
        end
        WRITE: begin
          Mem_Stall       = 1'b1;
          Memory_Write_En = 1'b1;
          Cache_Write_En  = hit_q && Mem_Done;
        end
        FLUSH: begin
          Mem_Stall   = 1'b1;
          tv_wr_en    = 1'b1;
          tv_wr_valid = 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Saturating counters; Flush does not touch them.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE) begin
      if (MemRead && !MemWrite && hit_c && (hit_count_q != '1)) begin
        hit_count_d = hit_count_q + 32'd1;
      end
      if (!Flush && !MemWrite && MemRead && !hit_c && (miss_count_q != '1)) begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign Hit_Count  = hit_count_q;
  assign Miss_Count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm_param.sv
// Scoreboard bench for cache_ctrl_dm_param: directed test-plan cases plus randomized traffic.
module tb_cache_ctrl_dm_param;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINES  = 32;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned LINE_BYTES = 4 * WORDS;
  localparam int unsigned SET_BYTES  = LINE_BYTES * LINES;

  localparam int EV_BEAT = 0;
  localparam int EV_WR   = 1;
  localparam int EV_RD   = 2;
  localparam int EV_FL   = 3;

  logic                      clk;
  logic                      rst;
  logic                      MemRead;
  logic                      MemWrite;
  logic                      Flush;
  logic [ADDR_W-1:0]         Address;
  logic                      Mem_Done;
  logic                      Mem_Stall;
  logic                      Cache_Read_En;
  logic                      Cache_Write_En;
  logic                      Memory_Read_En;
  logic                      Memory_Write_En;
  logic [$clog2(LINES)-1:0]  Line_number;
  logic [$clog2(WORDS)-1:0]  block_num_Addr;
  logic [TAG_W-1:0]          Addr_Tag;
  logic [ADDR_W-1:0]         Mem_Addr;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]               Hit_Count;
  logic [31:0]               Miss_Count;
`endif

  cache_ctrl_dm_param #(
    .ADDR_W (ADDR_W),
    .LINES  (LINES),
    .WORDS  (WORDS),
    .TAG_W  (TAG_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Flush           (Flush),
    .Address         (Address),
    .Mem_Done        (Mem_Done),
    .Mem_Stall       (Mem_Stall),
    .Cache_Read_En   (Cache_Read_En),
    .Cache_Write_En  (Cache_Write_En),
    .Memory_Read_En  (Memory_Read_En),
    .Memory_Write_En (Memory_Write_En),
    .Line_number     (Line_number),
    .block_num_Addr  (block_num_Addr),
    .Addr_Tag        (Addr_Tag),
    .Mem_Addr        (Mem_Addr)
`ifdef CACHE_PERF_CNT_EN
    ,
    .Hit_Count       (Hit_Count),
    .Miss_Count      (Miss_Count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          blk;
    bit          we;
    int          lat;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          mv[LINES];
  int unsigned mt[LINES];
  int          hits_m   = 0;
  int          misses_m = 0;
  int          lat_cnt  = 0;
  int          quiet_run = 0;

  // Reference view of the address: plain arithmetic on the byte address.
  function automatic int unsigned f_line(input logic [31:0] a);
    int unsigned ua = a;
    return (ua / LINE_BYTES) % LINES;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] a);
    int unsigned ua = a;
    return (ua / SET_BYTES) % (1 << TAG_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[f_line(a)] && (mt[f_line(a)] == f_tag(a));
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endfunction

  function automatic void push(input int kind, input logic [31:0] addr, input int blk,
                               input bit we, input int lat);
    ev_t e;
    e.kind = kind; e.addr = addr; e.blk = blk; e.we = we; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  function automatic void push_beats(input logic [31:0] a, input int n);
    int unsigned base = a - (a % LINE_BYTES);
    for (int k = 0; k < n; k++) push(EV_BEAT, 32'(base + 4 * k), k, 1'b1, -1);
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void observe(input int kind, input logic [31:0] addr, input int blk,
                                  input bit we, input int lat);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d addr=%h t=%0t", kind, addr, $time);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.addr !== addr || e.blk != blk || e.we != we ||
        (e.lat >= 0 && e.lat != lat)) begin
      bad++;
      $display("FAIL event got kind=%0d addr=%h blk=%0d we=%0d lat=%0d exp kind=%0d addr=%h blk=%0d we=%0d lat=%0d t=%0t",
               kind, addr, blk, we, lat, e.kind, e.addr, e.blk, e.we, e.lat, $time);
    end
  endfunction

  // Monitor: turns DUT output activity into events and matches them against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (Cache_Write_En) chk("cwe_only_with_done", 32'(Mem_Done), 32'd1);
      if (Memory_Read_En && Mem_Done)
        observe(EV_BEAT, Mem_Addr, int'(block_num_Addr), Cache_Write_En, 0);
      if (Memory_Write_En && Mem_Done)
        observe(EV_WR, Mem_Addr, 0, Cache_Write_En, 0);
      if (Cache_Read_En && !Mem_Stall)
        observe(EV_RD, Mem_Addr, 0, 1'b0, lat_cnt);
      if (Mem_Stall && !Memory_Read_En && !Memory_Write_En && !Flush && !MemRead && !MemWrite) begin
        quiet_run++;
      end else if (quiet_run > 0) begin
        observe(EV_FL, 32'(quiet_run), 0, 1'b0, 0);
        quiet_run = 0;
      end
    end
    if (rst || !MemRead || MemWrite || !Mem_Stall) lat_cnt = 0;
    else lat_cnt++;
  end

  bit resp_en = 1'b1;

  // Memory model: completes a beat with random latency while a request is open.
  initial begin
    Mem_Done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      Mem_Done = resp_en && (Memory_Read_En || Memory_Write_En) && ($urandom_range(0, 2) == 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s t=%0t", name, $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic do_read(input logic [31:0] a);
    int n = 0;
    if (m_hit(a)) begin
      push(EV_RD, a & ~32'd3, 0, 1'b0, 0);
    end else begin
      misses_m++;
      push_beats(a, WORDS);
      mv[f_line(a)] = 1'b1;
      mt[f_line(a)] = f_tag(a);
      push(EV_RD, a & ~32'd3, 0, 1'b0, -1);
    end
    hits_m++;
    cyc();
    MemRead = 1'b1;
    Address = a;
    forever begin
      @(negedge clk);
      if (!Mem_Stall) break;
      if (++n > 200) timeout("read");
    end
    cyc();
    MemRead = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input bit with_read);
    int n = 0;
    push(EV_WR, a & ~32'd3, 0, m_hit(a), 0);
    cyc();
    MemWrite = 1'b1;
    MemRead  = with_read;
    Address  = a;
    forever begin
      @(negedge clk);
      if (Memory_Write_En && Mem_Done) break;
      if (++n > 200) timeout("write");
    end
    cyc();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    m_clear();
    push(EV_FL, 32'(LINES), 0, 1'b0, 0);
    cyc();
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    forever begin
      @(negedge clk);
      if (!Mem_Stall) break;
      if (++n > 200) timeout("flush");
    end
  endtask

  // Miss that is aborted by reset after two refill beats.
  task automatic do_read_rst(input logic [31:0] a);
    int n = 0;
    int nb = 0;
    push_beats(a, 2);
    cyc();
    MemRead = 1'b1;
    Address = a;
    forever begin
      @(negedge clk);
      if (Memory_Read_En && Mem_Done) nb++;
      if (nb == 2) break;
      if (++n > 200) timeout("read_rst");
    end
    cyc();
    rst     = 1'b1;
    MemRead = 1'b0;
    m_clear();
    hits_m   = 0;
    misses_m = 0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 32'(Mem_Stall), 32'd0);
    chk("post_rst_mre", 32'(Memory_Read_En), 32'd0);
    chk("post_rst_mwe", 32'(Memory_Write_En), 32'd0);
    chk("post_rst_cwe", 32'(Cache_Write_En), 32'd0);
  endtask

  initial begin
    int unsigned r;
    logic [31:0] a;
    rst      = 1'b1;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Flush    = 1'b0;
    Address  = 32'h0000_0040;
    m_clear();
    for (int i = 0; i < LINES; i++) mt[i] = 0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_stall", 32'(Mem_Stall), 32'd0);
    chk("rst_mre", 32'(Memory_Read_En), 32'd0);
    chk("rst_mwe", 32'(Memory_Write_En), 32'd0);
    chk("rst_cwe", 32'(Cache_Write_En), 32'd0);
    chk("rst_cre", 32'(Cache_Read_En), 32'd1);
    cyc();
    rst     = 1'b0;
    MemRead = 1'b0;

    do_read(32'h0000_0040);
    do_read(32'h0000_0044);
    do_read(32'h0000_0240);
    do_read(32'h0000_0040);
    do_write(32'h0000_0044, 1'b0);
    do_write(32'h0000_0844, 1'b0);
    do_read(32'h0000_0844);
    do_read(32'h0000_0010);
    do_read(32'h0000_0050);
    do_flush();
    do_read(32'h0000_0010);
    do_read(32'h0000_0050);
    do_read_rst(32'h0000_0090);
    do_read(32'h0000_0090);
    do_write(32'h0000_0094, 1'b1);
    do_write(32'h0000_0A94, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      a = 32'($urandom_range(0, 7) * SET_BYTES * (1 << TAG_W) +
              $urandom_range(0, 3) * SET_BYTES +
              $urandom_range(0, 7) * LINE_BYTES +
              $urandom_range(0, WORDS - 1) * 4 +
              $urandom_range(0, 3));
      if (r < 50)      do_read(a);
      else if (r < 85) do_write(a, 1'b0);
      else if (r < 95) do_write(a, 1'b1);
      else             do_flush();
    end

    repeat (5) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    chk("hit_count", Hit_Count, 32'(hits_m));
    chk("miss_count", Miss_Count, 32'(misses_m));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("hit_count_rst", Hit_Count, 32'd0);
    chk("miss_count_rst", Miss_Count, 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
